// File: rtl/mobilenet_layer_scheduler.sv
// Layer sequencer: fetches each layer type, kicks its engine, waits with a watchdog.
// Optional per-layer cycle counter enabled by defining LAYER_PERF_CNT_EN.
module mobilenet_layer_scheduler #(
  parameter logic [5:0]  START_LAYER_ID = 6'd0,
  parameter logic [5:0]  MAX_LAYER_ID   = 6'd28,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd10_000_000
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        start,
  output logic [5:0]  cfg_layer_id,
  input  logic [2:0]  cfg_layer_type,
  output logic [4:0]  eng_start,
  input  logic [4:0]  eng_done,
  output logic        layer_start,
  output logic        layer_done,
  output logic [5:0]  current_layer,
  output logic [2:0]  fsm_state,
  output logic        done,
  output logic        error,
  output logic [31:0] perf_cycles
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_NEXT  = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  layer_q, layer_d;
  logic [2:0]  type_q, type_d;
  logic [31:0] wdog_q, wdog_d;
  logic [4:0]  type_oh;
  logic        hit;

  assign type_oh = 5'd1 << type_q;
  assign hit     = |(eng_done & type_oh);

  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    type_d  = type_q;
    wdog_d  = wdog_q;
    unique case (state_q)
      S_IDLE, S_ERR: begin
        if (start) begin
          layer_d = START_LAYER_ID;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        type_d  = cfg_layer_type;
        state_d = (cfg_layer_type > 3'd4) ? S_ERR : S_ISSUE;
      end
      S_ISSUE: begin
        wdog_d  = '0;
        state_d = S_WAIT;
      end
      // A match on the last watchdog cycle still wins over the timeout.
      S_WAIT: begin
        if (hit) begin
          state_d = S_NEXT;
        end else if (wdog_q == TIMEOUT_CYCLES - 32'd1) begin
          state_d = S_ERR;
        end else begin
          wdog_d = wdog_q + 32'd1;
        end
      end
      S_NEXT: begin
        if (layer_q == MAX_LAYER_ID) begin
          state_d = S_DONE;
        end else begin
          layer_d = layer_q + 6'd1;
          state_d = S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= S_IDLE;
      layer_q <= START_LAYER_ID;
      type_q  <= 3'd0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      type_q  <= type_d;
      wdog_q  <= wdog_d;
    end
  end

`ifdef LAYER_PERF_CNT_EN
  logic [31:0] perf_q;

  // Watchdog holds WAIT cycles before the match; add the match and ISSUE cycles.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      perf_q <= '0;
    end else if (state_q == S_WAIT && hit) begin
      perf_q <= wdog_q + 32'd2;
    end
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif

  assign cfg_layer_id  = layer_q;
  assign current_layer = layer_q;
  assign fsm_state     = state_q;
  assign eng_start     = (state_q == S_ISSUE) ? type_oh : 5'd0;
  assign layer_start   = (state_q == S_ISSUE);
  assign layer_done    = (state_q == S_NEXT);
  assign done          = (state_q == S_DONE);
  assign error         = (state_q == S_ERR);

endmodule
